// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: one word in, DATA_W registered bits out with sof/eof framing.
// Optional even-parity trailer bit when PAR2SER_PARITY_EN is defined.
//   state  | meaning
//   IDLE   | no frame, serial outputs low
//   SHIFT  | presenting data bits, cnt_q = bits presented so far
//   PARITY | presenting the parity trailer (PAR2SER_PARITY_EN only)
module par2ser_tx #(
  parameter int DATA_W        = 20,
  parameter bit MSB_FIRST_DEF = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              msb_first,
  output logic              s_out_port,
  output logic              s_valid,
  output logic              s_sof,
  output logic              s_eof,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(DATA_W - 1);

`ifdef PAR2SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ord_q, ord_d;
  logic              out_q, out_d;
  logic              vld_q, vld_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              rdy_q;
  logic              last_bit;
  logic              accept;

`ifdef PAR2SER_PARITY_EN
  assign last_bit = (state_q == PARITY);
`else
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif

  // rdy_q keeps load_ready low until the first edge after reset release
  assign load_ready = rdy_q && !clr && ((state_q == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ord_d   = ord_q;
    out_d   = 1'b0;
    vld_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
`ifdef PAR2SER_PARITY_EN
    par_d   = par_q;
`endif
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
    end else if (accept) begin
      state_d = SHIFT;
      ord_d   = msb_first;
      cnt_d   = CNT_W'(1);
      out_d   = msb_first ? data_in[DATA_W-1] : data_in[0];
      sh_d    = msb_first ? (data_in << 1) : (data_in >> 1);
      vld_d   = 1'b1;
      sof_d   = 1'b1;
`ifdef PAR2SER_PARITY_EN
      par_d   = ^data_in;
`endif
    end else if ((state_q == SHIFT) && (cnt_q != LAST_CNT)) begin
      out_d = ord_q ? sh_q[DATA_W-1] : sh_q[0];
      sh_d  = ord_q ? (sh_q << 1) : (sh_q >> 1);
      cnt_d = cnt_q + 1'b1;
      vld_d = 1'b1;
`ifndef PAR2SER_PARITY_EN
      eof_d = (cnt_q == PEN_CNT);
`endif
`ifdef PAR2SER_PARITY_EN
    end else if (state_q == SHIFT) begin
      state_d = PARITY;
      out_d   = par_q;
      cnt_d   = cnt_q + 1'b1;
      vld_d   = 1'b1;
      eof_d   = 1'b1;
`endif
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      ord_q   <= MSB_FIRST_DEF;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef PAR2SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ord_q   <= ord_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      rdy_q   <= 1'b1;
`ifdef PAR2SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign s_out_port = out_q;
  assign s_valid    = vld_q;
  assign s_sof      = sof_q;
  assign s_eof      = eof_q;
  assign busy       = (state_q != IDLE);

endmodule
